// File: rtl/adc_offset_cal_ctrl.sv
// ADC offset calibration controller: settles, averages 2^LOG2_N samples with
// round-half-up, and writes the mean to an offset register over a simple Avalon-MM write.
module adc_offset_cal_ctrl #(
    parameter int ADC_W        = 14,
    parameter int LOG2_N       = 10,
    parameter int RESET_OFFSET = 9732
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       settle_cycles,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              adc_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       offset_out,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata
);

    localparam int ACC_W = ADC_W + LOG2_N + 1;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_N) - 1);
    localparam logic [ACC_W-1:0] ROUND_HALF  = ACC_W'(1) << (LOG2_N - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACCUM   = 3'd2,
        AVERAGE = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [15:0]        settle_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   sample_cnt;
    logic [ADC_W-1:0]   mean;
    logic [ACC_W-1:0]   rounded;

    logic load_cal, settle_dec, acc_en, avg_en, commit;

    assign rounded = acc + ROUND_HALF;

    always_comb begin
        state_nxt  = state;
        load_cal   = 1'b0;
        settle_dec = 1'b0;
        acc_en     = 1'b0;
        avg_en     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                // abort outranks start in the same cycle
                if (start && !abort) begin
                    state_nxt = SETTLE;
                    load_cal  = 1'b1;
                end
            end
            SETTLE: begin
                if (abort)
                    state_nxt = IDLE;
                else if (settle_cnt <= 16'd1)
                    state_nxt = ACCUM;
                else
                    settle_dec = 1'b1;
            end
            ACCUM: begin
                if (abort)
                    state_nxt = IDLE;
                else if (adc_valid) begin
                    acc_en = 1'b1;
                    if (sample_cnt == LAST_SAMPLE)
                        state_nxt = AVERAGE;
                end
            end
            AVERAGE: begin
                if (abort)
                    state_nxt = IDLE;
                else begin
                    avg_en    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                commit    = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            acc        <= '0;
            sample_cnt <= '0;
            mean       <= '0;
            offset_out <= 32'(RESET_OFFSET);
        end else begin
            state <= state_nxt;
            if (load_cal) begin
                // a zero settle request still spends one cycle in SETTLE
                settle_cnt <= (settle_cycles == 16'd0) ? 16'd1 : settle_cycles;
                acc        <= '0;
                sample_cnt <= '0;
            end else begin
                if (settle_dec)
                    settle_cnt <= settle_cnt - 16'd1;
                if (acc_en) begin
                    acc        <= acc + ACC_W'(adc_data);
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
            if (avg_en)
                mean <= ADC_W'(rounded >> LOG2_N);
            if (commit)
                offset_out <= 32'(mean);
        end
    end

    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign avm_address    = 2'd0;
    assign avm_chipselect = (state == WRITE);
    assign avm_write_n    = (state != WRITE);
    assign avm_writedata  = (state == WRITE) ? 32'(mean) : 32'd0;

endmodule

// File: tb/tb_adc_offset_cal_ctrl.sv
// Directed bench for adc_offset_cal_ctrl with N = 16 samples per calibration.
module tb_adc_offset_cal_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [15:0] settle_cycles;
    logic [13:0] adc_data;
    logic        adc_valid;
    logic        busy;
    logic        done;
    logic [31:0] offset_out;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;

    int checks = 0;
    int errors = 0;

    int          wr_cnt;
    int          done_cnt;
    int          busy_cnt;
    logic [31:0] last_wd;

    adc_offset_cal_ctrl #(.ADC_W(14), .LOG2_N(4), .RESET_OFFSET(9732)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .settle_cycles(settle_cycles), .adc_data(adc_data), .adc_valid(adc_valid),
        .busy(busy), .done(done), .offset_out(offset_out),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observe each cycle's outputs just after the rising edge
    always @(posedge clk) begin
        #1;
        if (avm_chipselect && !avm_write_n) begin
            wr_cnt  = wr_cnt + 1;
            last_wd = avm_writedata;
        end
        if (done) done_cnt = done_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running wanted finished");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_cnt = 0; done_cnt = 0; busy_cnt = 0; last_wd = 32'hdead_beef;
    endtask

    // leaves the bench at the first negedge inside ACCUM
    task automatic begin_cal(input int s);
        settle_cycles = 16'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ((s == 0) ? 1 : s) @(negedge clk);
    endtask

    task automatic feed(input int val, input bit gap);
        adc_data  = 14'(val);
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; settle_cycles = '0;
        adc_data = '0; adc_valid = 1'b0;
        clear_mon();
        repeat (2) @(negedge clk);
        checks++;
        if (offset_out !== 32'd9732 || busy !== 1'b0 || avm_write_n !== 1'b1 ||
            avm_chipselect !== 1'b0 || done !== 1'b0 || avm_writedata !== 32'd0 ||
            avm_address !== 2'd0) begin
            errors++;
            $display("FAIL reset: offset=%0d busy=%b wn=%b cs=%b done=%b wd=%0d, wanted 9732 0 1 0 0 0",
                     offset_out, busy, avm_write_n, avm_chipselect, done, avm_writedata);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        clear_mon();
        begin_cal(5);
        for (int i = 0; i < 16; i++) feed(9800, 1'b0);
        checks++;
        if (busy !== 1'b1 || avm_chipselect !== 1'b0) begin
            errors++;
            $display("FAIL nominal_average: busy=%b cs=%b, wanted 1 0", busy, avm_chipselect);
        end
        @(negedge clk);
        checks++;
        if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0 || avm_address !== 2'd0 ||
            avm_writedata !== 32'd9800 || offset_out !== 32'd9732) begin
            errors++;
            $display("FAIL nominal_write: cs=%b wn=%b addr=%0d wd=%0d offset=%0d, wanted 1 0 0 9800 9732",
                     avm_chipselect, avm_write_n, avm_address, avm_writedata, offset_out);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || offset_out !== 32'd9800 || avm_chipselect !== 1'b0 ||
            avm_writedata !== 32'd0) begin
            errors++;
            $display("FAIL nominal_done: done=%b offset=%0d cs=%b wd=%0d, wanted 1 9800 0 0",
                     done, offset_out, avm_chipselect, avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL nominal_idle: busy=%b done=%b, wanted 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || done_cnt != 1 || busy_cnt != 24) begin
            errors++;
            $display("FAIL nominal_counts: writes=%0d dones=%0d busy_cycles=%0d, wanted 1 1 24",
                     wr_cnt, done_cnt, busy_cnt);
        end
    endtask

    task automatic test_rounding();
        clear_mon();
        begin_cal(2);
        for (int i = 0; i < 16; i++) feed((i < 8) ? 100 : 101, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || last_wd !== 32'd101 || offset_out !== 32'd101) begin
            errors++;
            $display("FAIL round_up: writes=%0d wd=%0d offset=%0d, wanted 1 101 101",
                     wr_cnt, last_wd, offset_out);
        end
        clear_mon();
        begin_cal(1);
        for (int i = 0; i < 16; i++) feed(100, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || last_wd !== 32'd100 || offset_out !== 32'd100) begin
            errors++;
            $display("FAIL round_exact: writes=%0d wd=%0d offset=%0d, wanted 1 100 100",
                     wr_cnt, last_wd, offset_out);
        end
    endtask

    task automatic test_full_scale();
        clear_mon();
        begin_cal(3);
        for (int i = 0; i < 16; i++) feed(16383, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || last_wd !== 32'd16383 || offset_out !== 32'd16383) begin
            errors++;
            $display("FAIL full_scale: writes=%0d wd=%0d offset=%0d, wanted 1 16383 16383",
                     wr_cnt, last_wd, offset_out);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        begin_cal(3);
        for (int i = 0; i < 7; i++) feed(1000, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_accum_idle: busy=%b, wanted 0", busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 0 || done_cnt != 0 || offset_out !== 32'd16383) begin
            errors++;
            $display("FAIL abort_no_write: writes=%0d dones=%0d offset=%0d, wanted 0 0 16383",
                     wr_cnt, done_cnt, offset_out);
        end
        settle_cycles = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_settle_idle: busy=%b, wanted 0", busy);
        end
        clear_mon();
        begin_cal(4);
        for (int i = 0; i < 16; i++) feed(50, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || last_wd !== 32'd50 || offset_out !== 32'd50) begin
            errors++;
            $display("FAIL abort_restart: writes=%0d wd=%0d offset=%0d, wanted 1 50 50",
                     wr_cnt, last_wd, offset_out);
        end
    endtask

    task automatic test_contention();
        clear_mon();
        begin_cal(3);
        for (int i = 0; i < 4; i++) feed(300, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) feed(300, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        checks++;
        if (avm_chipselect !== 1'b1 || avm_writedata !== 32'd300) begin
            errors++;
            $display("FAIL contention_write: cs=%b wd=%0d, wanted 1 300", avm_chipselect, avm_writedata);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_write_done: done=%b, wanted 1", done);
        end
        abort = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || done_cnt != 1 || offset_out !== 32'd300 || busy !== 1'b0) begin
            errors++;
            $display("FAIL contention_counts: writes=%0d dones=%0d offset=%0d busy=%b, wanted 1 1 300 0",
                     wr_cnt, done_cnt, offset_out, busy);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort_priority: busy=%b, wanted 0", busy);
        end
        clear_mon();
        settle_cycles = 16'd0;
        start = 1'b1;
        adc_data = 14'd4000;
        adc_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        adc_valid = 1'b0;
        for (int i = 0; i < 16; i++) feed(200, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || last_wd !== 32'd200 || busy_cnt != 20) begin
            errors++;
            $display("FAIL settle_zero: writes=%0d wd=%0d busy_cycles=%0d, wanted 1 200 20",
                     wr_cnt, last_wd, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_mon();
        begin_cal(1);
        for (int i = 0; i < 16; i++) feed(700, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 ||
            offset_out !== 32'd9732 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write: busy=%b cs=%b wn=%b offset=%0d done=%b, wanted 0 0 1 9732 0",
                     busy, avm_chipselect, avm_write_n, offset_out, done);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != 1 || done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write_after: writes=%0d dones=%0d busy=%b, wanted 1 0 0",
                     wr_cnt, done_cnt, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_rounding();
        test_full_scale();
        test_abort();
        test_contention();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
